// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN token sequencer: opcodes and FSM state encoding.
package rpn_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_AND = 2'd2;
    localparam logic [OP_W-1:0] OP_XOR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH    = 3'd1,
        S_POP_B   = 3'd2,
        S_LATCH_B = 3'd3,
        S_POP_A   = 3'd4,
        S_LATCH_A = 3'd5,
        S_PUSH_R  = 3'd6
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand ALU; 'a' is the deeper stack operand, results wrap modulo 2^WIDTH.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN token sequencer: pushes operands, pops two and pushes op(a,b) for each operator.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_empty,
    input  logic             stk_full,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             err_underflow,
    output logic             err_overflow,
    input  logic             err_clr
);

    state_t           r_state;
    state_t           w_next;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_acc;
    logic             w_set_un;
    logic             w_set_ov;
    logic             w_ld_operand;
    logic             w_ld_op;

    assign w_acc = tok_valid && tok_ready;

    // 'a' is consumed straight off the stack in LATCH_A so the result is registered
    // in time to be pushed in PUSH_R.
    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (stk_data_out),
        .b   (r_b),
        .op  (r_op),
        .res (w_alu_res)
    );

    always_comb begin
        w_next       = r_state;
        w_set_un     = 1'b0;
        w_set_ov     = 1'b0;
        w_ld_operand = 1'b0;
        w_ld_op      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (tok_is_op) begin
                        if (stk_empty) begin
                            w_set_un = 1'b1;
                        end else begin
                            w_ld_op = 1'b1;
                            w_next  = S_POP_B;
                        end
                    end else begin
                        if (stk_full) begin
                            w_set_ov = 1'b1;
                        end else begin
                            w_ld_operand = 1'b1;
                            w_next       = S_PUSH;
                        end
                    end
                end
            end
            S_PUSH:    w_next = S_IDLE;
            S_POP_B:   w_next = S_LATCH_B;
            S_LATCH_B: begin
                if (stk_empty) begin
                    w_set_un = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_next = S_POP_A;
                end
            end
            S_POP_A:   w_next = S_LATCH_A;
            S_LATCH_A: w_next = S_PUSH_R;
            S_PUSH_R:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are high during that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_b           <= '0;
            tok_ready     <= 1'b1;
            stk_push      <= 1'b0;
            stk_pop       <= 1'b0;
            stk_data_in   <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            r_state   <= w_next;
            tok_ready <= (w_next == S_IDLE);
            stk_push  <= (w_next == S_PUSH) || (w_next == S_PUSH_R);
            stk_pop   <= (w_next == S_POP_B) || (w_next == S_POP_A);
            res_valid <= (w_next == S_PUSH_R);
            if (w_ld_operand) stk_data_in <= tok_data;
            if (w_ld_op) r_op <= tok_data[OP_W-1:0];
            if (r_state == S_LATCH_B) r_b <= stk_data_out;
            if (r_state == S_LATCH_A) begin
                stk_data_in <= w_alu_res;
                res_data    <= w_alu_res;
            end
            if (w_set_un) err_underflow <= 1'b1;
            else if (err_clr) err_underflow <= 1'b0;
            if (w_set_ov) err_overflow <= 1'b1;
            else if (err_clr) err_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench: rpn_sequencer driving a behavioural 3-deep stack.
module tb_rpn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_is_op = 1'b0;
    logic [7:0] tok_data = 8'h00;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_data_in;
    logic [7:0] stk_data_out;
    logic       stk_empty;
    logic       stk_full;
    logic       res_valid;
    logic [7:0] res_data;
    logic       err_underflow;
    logic       err_overflow;
    logic       err_clr = 1'b0;

    always #5 clk = ~clk;

    rpn_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full),
        .res_valid(res_valid), .res_data(res_data),
        .err_underflow(err_underflow), .err_overflow(err_overflow), .err_clr(err_clr)
    );

    // Reference stack, DEPTH=3, reset from the same source as the sequencer.
    logic [7:0] smem [3];
    int         sdepth;
    logic [7:0] sdout;
    assign stk_data_out = sdout;
    assign stk_empty    = (sdepth == 0);
    assign stk_full     = (sdepth == 3);

    always @(posedge clk) begin
        if (!rst) begin
            sdepth <= 0;
            sdout  <= 8'h00;
        end else if (stk_push && sdepth < 3) begin
            smem[sdepth] <= stk_data_in;
            sdepth       <= sdepth + 1;
        end else if (stk_pop && sdepth > 0) begin
            sdout  <= smem[sdepth-1];
            sdepth <= sdepth - 1;
        end
    end

    // Event monitor: cycle index of each edge and strobe counts seen at edges.
    int         cyc = 0;
    int         npush = 0;
    int         npop = 0;
    int         nres = 0;
    int         res_cyc = 0;
    logic [7:0] last_res = 8'h00;
    bit         saw_dd = 1'b0;

    always @(posedge clk) begin
        if (stk_push) npush++;
        if (stk_push && stk_data_in == 8'hDD) saw_dd = 1'b1;
        if (stk_pop) npop++;
        if (res_valid) begin
            nres++;
            res_cyc  = cyc;
            last_res = res_data;
        end
        cyc++;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!tok_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk(tag, 0, 1);
    endtask

    task automatic send(input bit is_op, input logic [7:0] d);
        @(negedge clk);
        wait_ready("ready_timeout_pre");
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        @(posedge clk);
        #1;
        acc_cyc   = cyc - 1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = 8'h00;
        @(negedge clk);
        wait_ready("ready_timeout_post");
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int p0, q0, r0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tok_ready", tok_ready, 1);
        chk("rst_push", stk_push, 0);
        chk("rst_pop", stk_pop, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_errs", {err_underflow, err_overflow}, 0);
        rst = 1'b1;

        // 5 - 3
        send(0, 8'h05);
        send(0, 8'h03);
        r0 = nres;
        send(1, 8'h01);
        chk("sub_res_cnt", nres - r0, 1);
        chk("sub_res", last_res, 8'h02);
        chk("sub_res_data", res_data, 8'h02);
        chk("sub_latency", res_cyc - acc_cyc, 5);
        chk("sub_depth", sdepth, 1);
        chk("sub_top", smem[0], 8'h02);

        // FF + 02 wraps
        do_reset();
        send(0, 8'hFF);
        send(0, 8'h02);
        send(1, 8'h00);
        chk("add_wrap", res_data, 8'h01);
        chk("add_no_err", {err_underflow, err_overflow}, 0);
        chk("add_depth", sdepth, 1);

        // Overflow then XOR of the top two
        do_reset();
        send(0, 8'hAA);
        send(0, 8'hBB);
        send(0, 8'hCC);
        send(0, 8'hDD);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_no_push", saw_dd, 0);
        chk("ovf_depth", sdepth, 3);
        send(1, 8'h03);
        chk("xor_res", res_data, 8'h77);
        chk("xor_depth", sdepth, 2);
        chk("xor_bottom", smem[0], 8'hAA);

        // Underflow at accept, then underflow in LATCH_B
        do_reset();
        p0 = npop;
        send(1, 8'h00);
        chk("unf_acc_flag", err_underflow, 1);
        chk("unf_acc_nopop", npop - p0, 0);
        send(0, 8'h11);
        p0 = npop;
        r0 = nres;
        q0 = npush;
        send(1, 8'h02);
        chk("unf_b_pops", npop - p0, 1);
        chk("unf_b_flag", err_underflow, 1);
        chk("unf_b_empty", stk_empty, 1);
        chk("unf_b_nores", nres - r0, 0);
        chk("unf_b_nopush", npush - q0, 0);

        // Sticky clear, and set beating clear in the same cycle
        send(0, 8'h01);
        send(0, 8'h02);
        send(0, 8'h03);
        send(0, 8'h04);
        chk("both_set", {err_underflow, err_overflow}, 2'b11);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_both", {err_underflow, err_overflow}, 0);
        @(negedge clk);
        err_clr   = 1'b1;
        tok_valid = 1'b1;
        tok_data  = 8'h05;
        @(posedge clk);
        #1;
        err_clr   = 1'b0;
        tok_valid = 1'b0;
        chk("set_wins_ov", err_overflow, 1);
        chk("set_wins_un", err_underflow, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_again", err_overflow, 0);

        // Reset while in POP_A
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = 8'h00;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("popa_pop", stk_pop, 1);
        chk("popa_busy", tok_ready, 0);
        r0 = nres;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstop_strobes", {stk_push, stk_pop, res_valid}, 0);
        chk("rstop_ready", tok_ready, 1);
        chk("rstop_depth", sdepth, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rstop_no_res", nres - r0, 0);
        chk("rstop_idle", tok_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
